// File: rtl/ip_next_hop_resolver.sv
// ip_next_hop_resolver
//
// Resolves the next-hop MAC address for one outgoing IP datagram at a time.
// The destination IP is presented to the external broadcast/subnet/local
// checker and held there. Once the slowest checker flag has settled, one
// decision is made:
//   - Broadcast or subnet broadcast: return the all-ones MAC, with no ARP.
//   - Multicast (224/4): return the mapped 01:00:5e MAC, with no ARP.
//   - Local: send an ARP lookup for the destination IP itself.
//   - Remote: send an ARP lookup for the gateway. If no gateway is set,
//     return an error instead.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   s_req_*                    request channel (valid/ready, destination IP)
//   chk_dest_ip                destination IP driven into the checker
//   chk_is_*                   classification flags from the checker
//   gateway_ip                 default gateway; 0 means no gateway
//   subnet_mask                routed to the checker only; unused here
//   m_arp_req_*                ARP lookup request (valid/ready, IP)
//   s_arp_resp_*               ARP lookup response (valid/ready, error, MAC)
//   m_res_*                    result (valid/ready, MAC, error, broadcast)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a request; s_req_ready high
// WAIT_CHK | destination IP is on the checker; waiting for the flags
// DECIDE   | all flags are valid; choose the resolution path
// ARP_REQ  | ARP lookup request presented, waiting for the handshake
// ARP_WAIT | waiting for the ARP response, bounded by ARP_TIMEOUT
// RESULT   | result presented, held until m_res_ready
module ip_next_hop_resolver #(
    parameter int CHECK_LATENCY = 4,
    parameter int ARP_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s_req_valid,
    output logic        s_req_ready,
    input  logic [31:0] s_req_ip,

    output logic [31:0] chk_dest_ip,
    input  logic        chk_is_broadcast,
    input  logic        chk_is_subnet_broadcast,
    input  logic        chk_is_local,

    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask,

    output logic        m_arp_req_valid,
    input  logic        m_arp_req_ready,
    output logic [31:0] m_arp_req_ip,

    input  logic        s_arp_resp_valid,
    output logic        s_arp_resp_ready,
    input  logic        s_arp_resp_error,
    input  logic [47:0] s_arp_resp_mac,

    output logic        m_res_valid,
    input  logic        m_res_ready,
    output logic [47:0] m_res_mac,
    output logic        m_res_error,
    output logic        m_res_broadcast
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_CHK = 3'd1;
    localparam logic [2:0] ST_DECIDE   = 3'd2;
    localparam logic [2:0] ST_ARP_REQ  = 3'd3;
    localparam logic [2:0] ST_ARP_WAIT = 3'd4;
    localparam logic [2:0] ST_RESULT   = 3'd5;

    // One down-counter serves both the checker settle wait and the ARP
    // timeout, because those two waits never overlap. Each wait loads the
    // counter with its length minus one and ends when the counter is zero.
    localparam int CNT_MAX  = (ARP_TIMEOUT > CHECK_LATENCY) ? ARP_TIMEOUT : CHECK_LATENCY;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int CHK_LOAD = (CHECK_LATENCY > 0) ? CHECK_LATENCY - 1 : 0;
    localparam int ARP_LOAD = (ARP_TIMEOUT > 0) ? ARP_TIMEOUT - 1 : 0;

    localparam logic [47:0] MAC_BCAST      = 48'hffff_ffff_ffff;
    localparam logic [23:0] MCAST_OUI      = 24'h01_00_5e;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             req_hs;
    logic             dec_bcast;
    logic             dec_mcast;
    logic             no_gateway;

    // The mask belongs to the checker; it is not used inside this block.
    logic             unused_subnet_mask;
    assign unused_subnet_mask = ^subnet_mask;

    assign req_hs     = s_req_valid && s_req_ready;
    assign cnt_zero   = (cnt == '0);
    assign dec_bcast  = chk_is_broadcast || chk_is_subnet_broadcast;
    assign dec_mcast  = (chk_dest_ip[31:28] == 4'he);
    assign no_gateway = (gateway_ip == 32'd0);

    assign m_arp_req_valid  = (state == ST_ARP_REQ);
    assign s_arp_resp_ready = (state == ST_ARP_WAIT);
    assign m_res_valid      = (state == ST_RESULT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_hs) begin
                    state_nxt = ST_WAIT_CHK;
                end
            end
            ST_WAIT_CHK: begin
                if (cnt_zero) begin
                    state_nxt = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (dec_bcast || dec_mcast) begin
                    state_nxt = ST_RESULT;
                end else if (chk_is_local) begin
                    state_nxt = ST_ARP_REQ;
                end else if (no_gateway) begin
                    state_nxt = ST_RESULT;
                end else begin
                    state_nxt = ST_ARP_REQ;
                end
            end
            ST_ARP_REQ: begin
                if (m_arp_req_ready) begin
                    state_nxt = ST_ARP_WAIT;
                end
            end
            ST_ARP_WAIT: begin
                // A response in the final timeout cycle still leads to
                // RESULT; the datapath gives the response priority.
                if (s_arp_resp_valid || cnt_zero) begin
                    state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (m_res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            s_req_ready     <= 1'b0;
            chk_dest_ip     <= 32'd0;
            m_arp_req_ip    <= 32'd0;
            m_res_mac       <= 48'd0;
            m_res_error     <= 1'b0;
            m_res_broadcast <= 1'b0;
        end else begin
            state <= state_nxt;
            // s_req_ready is registered so that it reads 0 while reset is
            // asserted, even though IDLE is the reset state.
            s_req_ready <= (state_nxt == ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (req_hs) begin
                        chk_dest_ip     <= s_req_ip;
                        cnt             <= CNT_W'(CHK_LOAD);
                        m_res_mac       <= 48'd0;
                        m_res_error     <= 1'b0;
                        m_res_broadcast <= 1'b0;
                    end
                end
                ST_WAIT_CHK: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DECIDE: begin
                    if (dec_bcast) begin
                        m_res_mac       <= MAC_BCAST;
                        m_res_broadcast <= 1'b1;
                    end else if (dec_mcast) begin
                        // RFC 1112 mapping: only the low 23 group bits
                        // appear in the MAC address.
                        m_res_mac       <= {MCAST_OUI, 1'b0, chk_dest_ip[22:0]};
                        m_res_broadcast <= 1'b1;
                    end else if (chk_is_local) begin
                        m_arp_req_ip    <= chk_dest_ip;
                    end else if (no_gateway) begin
                        m_res_mac       <= 48'd0;
                        m_res_error     <= 1'b1;
                    end else begin
                        m_arp_req_ip    <= gateway_ip;
                    end
                end
                ST_ARP_REQ: begin
                    if (m_arp_req_ready) begin
                        cnt <= CNT_W'(ARP_LOAD);
                    end
                end
                ST_ARP_WAIT: begin
                    if (s_arp_resp_valid) begin
                        m_res_mac   <= s_arp_resp_error ? 48'd0 : s_arp_resp_mac;
                        m_res_error <= s_arp_resp_error;
                    end else if (cnt_zero) begin
                        m_res_mac   <= 48'd0;
                        m_res_error <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
